// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Arbitrates the single register-file write port between the one-cycle ALU
//   writeback and the multi-cycle load writeback. It also keeps a pending-write
//   scoreboard for x1..x31, which decode uses to stall on RAW and WAW hazards.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   issue_valid/rd/rs1/rs2
//                       the instruction currently in decode
//   stall               combinational; decode holds while this is high
//   alu_valid/rd/data   ALU writeback request; alu_ready is its grant
//   mem_valid/rd/data   load writeback request; mem_ready is its grant
//   wr_en/wr_rd/wr_data registered drive to the register file write port
//   pending             scoreboard bitmap, for debug
module regfile_wb_scheduler #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [RA_W-1:0]  issue_rd,
  input  logic [RA_W-1:0]  issue_rs1,
  input  logic [RA_W-1:0]  issue_rs2,
  output logic             stall,
  input  logic             alu_valid,
  input  logic [RA_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  output logic             mem_ready,
  output logic             wr_en,
  output logic [RA_W-1:0]  wr_rd,
  output logic [XLEN-1:0]  wr_data,
  output logic [NREGS-1:0] pending
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e             last_grant_reg, last_grant_next;
  logic [NREGS-1:0] pending_reg, pending_next;
  logic             wr_en_reg;
  logic [RA_W-1:0]  wr_rd_reg;
  logic [XLEN-1:0]  wr_data_reg;

  logic             accept;
  logic [RA_W-1:0]  acc_rd;
  logic [XLEN-1:0]  acc_data;
  logic             issue_fire;
  logic             rs1_busy, rs2_busy, rd_busy;

  // x0 is masked explicitly even though pending_reg[0] is never set.
  assign rs1_busy = (issue_rs1 != '0) && pending_reg[issue_rs1];
  assign rs2_busy = (issue_rs2 != '0) && pending_reg[issue_rs2];
  assign rd_busy  = (issue_rd  != '0) && pending_reg[issue_rd];
  assign stall    = issue_valid && (rs1_busy || rs2_busy || rd_busy);

  assign issue_fire = issue_valid && !stall && (issue_rd != '0);

  // Round-robin: when both sources request, the one not served last wins.
  assign alu_ready = alu_valid && (!mem_valid || (last_grant_reg == SRC_MEM));
  assign mem_ready = mem_valid && (!alu_valid || (last_grant_reg == SRC_ALU));

  always_comb begin
    accept          = 1'b0;
    acc_rd          = '0;
    acc_data        = '0;
    last_grant_next = last_grant_reg;
    if (alu_ready) begin
      accept          = 1'b1;
      acc_rd          = alu_rd;
      acc_data        = alu_data;
      last_grant_next = SRC_ALU;
    end else if (mem_ready) begin
      accept          = 1'b1;
      acc_rd          = mem_rd;
      acc_data        = mem_data;
      last_grant_next = SRC_MEM;
    end
  end

  // Per-register scoreboard update. A set from issue takes priority over a
  // clear from an accepted write so that the newer writer stays tracked.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
      if (gi == 0) begin : g_x0
        assign pending_next[gi] = 1'b0;
      end else begin : g_xn
        logic set_hit, clr_hit;
        assign set_hit = issue_fire && (issue_rd == RA_W'(gi));
        assign clr_hit = accept && (acc_rd == RA_W'(gi));
        assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg    <= '0;
      wr_en_reg      <= 1'b0;
      wr_rd_reg      <= '0;
      wr_data_reg    <= '0;
      last_grant_reg <= SRC_MEM;
    end else begin
      pending_reg    <= pending_next;
      last_grant_reg <= last_grant_next;
      // A write to x0 is consumed but never reaches the register file.
      wr_en_reg      <= accept && (acc_rd != '0);
      if (accept) begin
        wr_rd_reg   <= acc_rd;
        wr_data_reg <= acc_data;
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_rd   = wr_rd_reg;
  assign wr_data = wr_data_reg;
  assign pending = pending_reg;

endmodule
